huffman_merge_ctrl: RTL

- Sequences the merge phase of the 6-symbol Huffman coder.
- Takes the per-symbol counts from the counting stage and drives the shared sorter through 5 sort/merge rounds.
- Builds each symbol's code (HC) and length mask (M) bit by bit, then pulses code_valid.
- Sits between the count stage and the HC/M outputs; owns the sorter's request/acknowledge handshake.

---
 rtl/huffman_pkg.sv | 41 ++++
 rtl/huffman_code_acc.sv | 60 ++++++
 rtl/huffman_merge_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants, FSM state type, slot-bus field helpers and
// the saturating count adder for the 6-symbol Huffman merge controller.
// Used by huffman_merge_ctrl (optional macro HUFF_SORT_TIMEOUT_EN) and huffman_code_acc.
package huffman_pkg;

    localparam int unsigned NSYM  = 6;
    localparam int unsigned SYM_W = 8;
    localparam int unsigned BUS_W = NSYM * SYM_W;
    localparam int unsigned NRND  = NSYM - 1;
    localparam int unsigned RND_W = 3;

    typedef logic [SYM_W-1:0] sym_t;
    typedef logic [BUS_W-1:0] bus_t;
    typedef logic [NSYM-1:0]  mask_t;
    typedef logic [RND_W-1:0] rnd_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, MERGE, DONE} state_e;

    // Slot/symbol field s of a bus; field 0 is the most significant byte.
    function automatic sym_t slot_get(input bus_t bus, input int unsigned s);
        return bus[(NSYM-1-s)*SYM_W +: SYM_W];
    endfunction

    function automatic bus_t slot_set(input bus_t bus, input int unsigned s, input sym_t v);
        bus_t r;
        r = bus;
        r[(NSYM-1-s)*SYM_W +: SYM_W] = v;
        return r;
    endfunction

    // Count addition clamped at all-ones instead of wrapping.
    function automatic sym_t sat_add(input sym_t a, input sym_t b);
        logic [SYM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SYM_W]) begin
            return '1;
        end
        return sum[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/huffman_code_acc.sv
// huffman_code_acc: per-symbol code (HC) and length-mask (M) accumulator.
// Symbols in mask1 append a 1, symbols in mask0 append a 0, at bit position len
// where len is the current code length (popcount of the symbol's M field).
module huffman_code_acc
    import huffman_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clr_i,
    input  logic  en_i,
    input  mask_t mask1_i,
    input  mask_t mask0_i,
    output bus_t  hc_o,
    output bus_t  m_o
);

    bus_t hc_q, hc_d;
    bus_t m_q, m_d;
    sym_t hc_f, m_f;

    // Next code/mask: clear on new job, else append one bit to each selected symbol.
    always_comb begin
        hc_d = hc_q;
        m_d  = m_q;
        hc_f = '0;
        m_f  = '0;
        if (clr_i) begin
            hc_d = '0;
            m_d  = '0;
        end else if (en_i) begin
            for (int unsigned j = 0; j < NSYM; j++) begin
                if (mask1_i[j] || mask0_i[j]) begin
                    hc_f = slot_get(hc_q, j);
                    m_f  = slot_get(m_q, j);
                    if (mask1_i[j]) begin
                        hc_f = hc_f | (sym_t'(1) << $countones(m_f));
                    end
                    m_f  = (m_f << 1) | sym_t'(1);
                    hc_d = slot_set(hc_d, j, hc_f);
                    m_d  = slot_set(m_d, j, m_f);
                end
            end
        end
    end

    // Code and mask registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hc_q <= '0;
            m_q  <= '0;
        end else begin
            hc_q <= hc_d;
            m_q  <= m_d;
        end
    end

    assign hc_o = hc_q;
    assign m_o  = m_q;

endmodule

// File: rtl/huffman_merge_ctrl.sv
// huffman_merge_ctrl: sequences 5 sort/merge rounds of the 6-symbol Huffman coder
// through an external sorter (srt_req/srt_ack) and pulses code_valid when HC/M are final.
// Optional: define HUFF_SORT_TIMEOUT_EN to add the sort_err output and a WAIT watchdog
// of TIMEOUT cycles.
module huffman_merge_ctrl
    import huffman_pkg::*;
`ifdef HUFF_SORT_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 64
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             CNT_valid,
    input  logic [BUS_W-1:0] CNT,
    output logic             srt_req,
    output logic [BUS_W-1:0] out_Aid_all,
    output logic [BUS_W-1:0] out_CNT_all,
    input  logic             srt_ack,
    input  logic [BUS_W-1:0] in_Aid_all,
    input  logic [BUS_W-1:0] in_CNT_all,
    output logic             code_valid,
    output logic [BUS_W-1:0] HC,
    output logic [BUS_W-1:0] M,
    output logic             busy
`ifdef HUFF_SORT_TIMEOUT_EN
    ,
    output logic             sort_err
`endif
);

    state_e      state_q, state_d;
    bus_t        aid_q, aid_d;
    bus_t        cnt_q, cnt_d;
    rnd_t        rnd_q, rnd_d;

    logic        capture, ack_take, merge_en, timeout_hit;
    int unsigned idx_last, idx_prev;
    sym_t        aid_last, aid_prev, cnt_last, cnt_prev;

`ifdef HUFF_SORT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             sort_err_q, sort_err_d;
`endif

    assign capture  = (state_q == IDLE) && CNT_valid;
    assign ack_take = (state_q == WAIT) && srt_ack;
    assign merge_en = (state_q == MERGE);

    // Active-slot indices for this round: k-1 (smallest) and k-2, k = NSYM - rnd.
    // rnd reaches NRND in DONE; the clamp keeps the indices in range outside MERGE.
    always_comb begin
        idx_last = NSYM - 1 - ((32'(rnd_q) < NRND) ? 32'(rnd_q) : 0);
        idx_prev = idx_last - 1;
        aid_last = slot_get(aid_q, idx_last);
        aid_prev = slot_get(aid_q, idx_prev);
        cnt_last = slot_get(cnt_q, idx_last);
        cnt_prev = slot_get(cnt_q, idx_prev);
    end

`ifdef HUFF_SORT_TIMEOUT_EN
    // Watchdog: count WAIT cycles without an acknowledge.
    always_comb begin
        tmo_d       = '0;
        timeout_hit = 1'b0;
        if ((state_q == WAIT) && !srt_ack) begin
            tmo_d       = tmo_q + 1'b1;
            timeout_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
        end
        sort_err_d = timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic of the round sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (CNT_valid) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT: begin
                if (srt_ack) begin
                    state_d = MERGE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            MERGE:   state_d = (rnd_q == rnd_t'(NRND - 1)) ? DONE : REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slot datapath: initial load, sorter capture, and pairwise merge of the two smallest.
    always_comb begin
        aid_d = aid_q;
        cnt_d = cnt_q;
        rnd_d = rnd_q;
        if (capture) begin
            for (int unsigned s = 0; s < NSYM; s++) begin
                aid_d = slot_set(aid_d, s, sym_t'(1) << s);
                cnt_d = slot_set(cnt_d, s, slot_get(CNT, s));
            end
            rnd_d = '0;
        end else if (ack_take) begin
            aid_d = in_Aid_all;
            cnt_d = in_CNT_all;
        end else if (merge_en) begin
            aid_d = slot_set(aid_d, idx_prev, aid_prev | aid_last);
            cnt_d = slot_set(cnt_d, idx_prev, sat_add(cnt_prev, cnt_last));
            aid_d = slot_set(aid_d, idx_last, '0);
            cnt_d = slot_set(cnt_d, idx_last, '0);
            rnd_d = rnd_q + rnd_t'(1);
        end
    end

    // State and slot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            aid_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            aid_q   <= aid_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
        end
    end

`ifdef HUFF_SORT_TIMEOUT_EN
    // Watchdog counter and one-cycle error pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q      <= '0;
            sort_err_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            sort_err_q <= sort_err_d;
        end
    end

    assign sort_err = sort_err_q;
`endif

    // Outputs decoded from state; sorter buses come straight from the slot registers.
    always_comb begin
        srt_req     = (state_q == REQ) || (state_q == WAIT);
        code_valid  = (state_q == DONE);
        busy        = (state_q != IDLE);
        out_Aid_all = aid_q;
        out_CNT_all = cnt_q;
    end

    huffman_code_acc u_code_acc (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (capture),
        .en_i    (merge_en),
        .mask1_i (aid_last[NSYM-1:0]),
        .mask0_i (aid_prev[NSYM-1:0]),
        .hc_o    (HC),
        .m_o     (M)
    );

endmodule
